cell_grid_scanner: RTL and testbench

Upstream video source for the 24-bit-to-256-bit stream packer. Raster-scans a WIDTH×HEIGHT frame, eight pixels per beat, and renders the matrix cell bitmap as a grid of FG/BG-coloured cells separated by one-pixel grid lines. Drives the packer's pixel input with `sof`/`eol` framing and honours its `ready` back-pressure. Bitmap and colours are snapshotted per frame, so a frame never tears.

---
 rtl/video_pkg.sv | 20 ++
 rtl/raster_counter.sv | 111 +++++++++++
 rtl/cell_grid_scanner.sv | 154 +++++++++++++++
 tb/tb_cell_grid_scanner.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/video_pkg.sv
// Shared pixel/beat constants, FSM encoding and colour type for the video source path.
package video_pkg;

    localparam int unsigned PIX_BITS     = 24;
    localparam int unsigned PIX_PER_BEAT = 8;
    localparam int unsigned BEAT_BITS    = PIX_BITS * PIX_PER_BEAT;

    typedef enum logic {StIdle, StActive} state_t;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb_t;

    function automatic int unsigned idx_width(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/raster_counter.sv
// Incremental raster position chain; exposes next-state position so the owner can
// register the beat that matches the position being loaded.
module raster_counter
    import video_pkg::*;
#(
    parameter int unsigned WIDTH     = 640,
    parameter int unsigned HEIGHT    = 480,
    parameter int unsigned CELL_W    = 80,
    parameter int unsigned CELL_H    = 60,
    parameter int unsigned GRID_COLS = 8,
    parameter int unsigned GRID_ROWS = 8,
    localparam int unsigned BXW = idx_width(WIDTH / 8),
    localparam int unsigned CW  = idx_width(GRID_COLS),
    localparam int unsigned COW = idx_width(CELL_W),
    localparam int unsigned YW  = idx_width(HEIGHT),
    localparam int unsigned RW  = idx_width(GRID_ROWS),
    localparam int unsigned ROW = idx_width(CELL_H)
) (
    input  logic           aclk,
    input  logic           areset,
    input  logic           advance,
    input  logic           clear,
    output logic [BXW-1:0] nxt_beat_x,
    output logic [CW-1:0]  nxt_col,
    output logic [COW-1:0] nxt_col_off,
    output logic [YW-1:0]  nxt_y,
    output logic [RW-1:0]  nxt_row,
    output logic [ROW-1:0] nxt_row_off,
    output logic           last_in_line,
    output logic           last_in_frame
);

    localparam logic [BXW-1:0] BxLast = BXW'(WIDTH / 8 - 1);
    localparam logic [COW-1:0] CoLast = COW'(CELL_W - 8);
    localparam logic [COW-1:0] CoStep = COW'(8);
    localparam logic [YW-1:0]  YLast  = YW'(HEIGHT - 1);
    localparam logic [ROW-1:0] RoLast = ROW'(CELL_H - 1);

    logic [BXW-1:0] beat_x_q;
    logic [CW-1:0]  col_q;
    logic [COW-1:0] col_off_q;
    logic [YW-1:0]  y_q;
    logic [RW-1:0]  row_q;
    logic [ROW-1:0] row_off_q;

    assign last_in_line  = (beat_x_q == BxLast);
    assign last_in_frame = last_in_line && (y_q == YLast);

    always_comb begin
        nxt_beat_x  = beat_x_q;
        nxt_col     = col_q;
        nxt_col_off = col_off_q;
        nxt_y       = y_q;
        nxt_row     = row_q;
        nxt_row_off = row_off_q;
        if (clear) begin
            nxt_beat_x  = '0;
            nxt_col     = '0;
            nxt_col_off = '0;
            nxt_y       = '0;
            nxt_row     = '0;
            nxt_row_off = '0;
        end else if (advance) begin
            if (last_in_line) begin
                nxt_beat_x  = '0;
                nxt_col     = '0;
                nxt_col_off = '0;
                if (last_in_frame) begin
                    nxt_y       = '0;
                    nxt_row     = '0;
                    nxt_row_off = '0;
                end else begin
                    nxt_y = y_q + YW'(1);
                    if (row_off_q == RoLast) begin
                        nxt_row_off = '0;
                        nxt_row     = row_q + RW'(1);
                    end else begin
                        nxt_row_off = row_off_q + ROW'(1);
                    end
                end
            end else begin
                nxt_beat_x = beat_x_q + BXW'(1);
                if (col_off_q == CoLast) begin
                    nxt_col_off = '0;
                    nxt_col     = col_q + CW'(1);
                end else begin
                    nxt_col_off = col_off_q + CoStep;
                end
            end
        end
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            beat_x_q  <= '0;
            col_q     <= '0;
            col_off_q <= '0;
            y_q       <= '0;
            row_q     <= '0;
            row_off_q <= '0;
        end else begin
            beat_x_q  <= nxt_beat_x;
            col_q     <= nxt_col;
            col_off_q <= nxt_col_off;
            y_q       <= nxt_y;
            row_q     <= nxt_row;
            row_off_q <= nxt_row_off;
        end
    end

endmodule

// File: rtl/cell_grid_scanner.sv
// Raster source rendering a cell bitmap as FG/BG cells with grid lines, 8 pixels per beat,
// with per-frame snapshots of bitmap and colours and ready/valid back-pressure.
module cell_grid_scanner
    import video_pkg::*;
#(
    parameter int unsigned WIDTH     = 640,
    parameter int unsigned HEIGHT    = 480,
    parameter int unsigned CELL_W    = 80,
    parameter int unsigned CELL_H    = 60,
    parameter int unsigned GRID_COLS = 8,
    parameter int unsigned GRID_ROWS = 8
) (
    input  logic                           aclk,
    input  logic                           areset,
    input  logic                           enable,
    input  logic [GRID_ROWS*GRID_COLS-1:0] cell_bits,
    input  logic [PIX_BITS-1:0]            fg_colour,
    input  logic [PIX_BITS-1:0]            bg_colour,
    input  logic [PIX_BITS-1:0]            grid_colour,
    output logic [BEAT_BITS-1:0]           rgb_out,
    output logic                           valid,
    input  logic                           ready,
    output logic                           sof,
    output logic                           eol,
    output logic                           frame_done
);

    localparam int unsigned BXW = idx_width(WIDTH / 8);
    localparam int unsigned CW  = idx_width(GRID_COLS);
    localparam int unsigned COW = idx_width(CELL_W);
    localparam int unsigned YW  = idx_width(HEIGHT);
    localparam int unsigned RW  = idx_width(GRID_ROWS);
    localparam int unsigned ROW = idx_width(CELL_H);
    localparam logic [BXW-1:0] BxLast = BXW'(WIDTH / 8 - 1);

    state_t state_q;
    logic [GRID_ROWS-1:0][GRID_COLS-1:0] bits_q, bits_d;
    rgb_t fg_q, bg_q, grid_q, fg_d, bg_d, grid_d;

    logic [BXW-1:0] nxt_beat_x;
    logic [CW-1:0]  nxt_col;
    logic [COW-1:0] nxt_col_off;
    logic [YW-1:0]  nxt_y;
    logic [RW-1:0]  nxt_row;
    logic [ROW-1:0] nxt_row_off;
    logic           last_in_line, last_in_frame;

    logic accept, frame_end, load, advance;
    logic sof_d, eol_d, cell_on;
    logic [BEAT_BITS-1:0] beat_d;

    assign accept    = (state_q == StActive) && ready;
    assign frame_end = accept && last_in_line && last_in_frame;
    // A load starts a frame: from idle, or back-to-back after the final beat.
    assign load      = enable && ((state_q == StIdle) || frame_end);
    assign advance   = accept && !load;

    raster_counter #(
        .WIDTH     (WIDTH),
        .HEIGHT    (HEIGHT),
        .CELL_W    (CELL_W),
        .CELL_H    (CELL_H),
        .GRID_COLS (GRID_COLS),
        .GRID_ROWS (GRID_ROWS)
    ) u_raster_counter (
        .aclk          (aclk),
        .areset        (areset),
        .advance       (advance),
        .clear         (load),
        .nxt_beat_x    (nxt_beat_x),
        .nxt_col       (nxt_col),
        .nxt_col_off   (nxt_col_off),
        .nxt_y         (nxt_y),
        .nxt_row       (nxt_row),
        .nxt_row_off   (nxt_row_off),
        .last_in_line  (last_in_line),
        .last_in_frame (last_in_frame)
    );

    assign bits_d = load ? cell_bits   : bits_q;
    assign fg_d   = load ? fg_colour   : fg_q;
    assign bg_d   = load ? bg_colour   : bg_q;
    assign grid_d = load ? grid_colour : grid_q;

    assign cell_on = bits_d[nxt_row][nxt_col];
    assign sof_d   = (nxt_y == '0) && (nxt_beat_x == '0);
    assign eol_d   = (nxt_beat_x == BxLast);

    always_comb begin
        beat_d = '0;
        for (int unsigned i = 0; i < PIX_PER_BEAT; i++) begin
            rgb_t pix;
            pix = grid_d;
            if (nxt_row_off != '0 && !(i == 0 && nxt_col_off == '0)) begin
                pix = cell_on ? fg_d : bg_d;
            end
            beat_d[i*PIX_BITS +: PIX_BITS] = pix;
        end
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            bits_q <= '0;
            fg_q   <= '0;
            bg_q   <= '0;
            grid_q <= '0;
        end else begin
            bits_q <= bits_d;
            fg_q   <= fg_d;
            bg_q   <= bg_d;
            grid_q <= grid_d;
        end
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state_q    <= StIdle;
            valid      <= 1'b0;
            sof        <= 1'b0;
            eol        <= 1'b0;
            rgb_out    <= '0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= frame_end;
            case (state_q)
                StIdle: begin
                    if (enable) begin
                        state_q <= StActive;
                        valid   <= 1'b1;
                        sof     <= sof_d;
                        eol     <= eol_d;
                        rgb_out <= beat_d;
                    end
                end
                StActive: begin
                    if (accept) begin
                        if (frame_end && !enable) begin
                            state_q <= StIdle;
                            valid   <= 1'b0;
                            sof     <= 1'b0;
                            eol     <= 1'b0;
                        end else begin
                            sof     <= sof_d;
                            eol     <= eol_d;
                            rgb_out <= beat_d;
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_cell_grid_scanner.sv
// Directed bench for cell_grid_scanner on a 32x4 frame of 2x2 cells (16 beats per frame).
module tb_cell_grid_scanner;

    localparam logic [23:0] FG   = 24'hFF0000;
    localparam logic [23:0] BG   = 24'h0000FF;
    localparam logic [23:0] GRID = 24'h00FF00;

    logic         aclk = 1'b0;
    logic         areset;
    logic         enable;
    logic         ready;
    logic [3:0]   cell_bits;
    logic [191:0] rgb_out;
    logic         valid, sof, eol, frame_done;

    int n_cmp = 0;
    int n_err = 0;

    always #5 aclk = ~aclk;

    cell_grid_scanner #(
        .WIDTH     (32),
        .HEIGHT    (4),
        .CELL_W    (16),
        .CELL_H    (2),
        .GRID_COLS (2),
        .GRID_ROWS (2)
    ) dut (
        .aclk        (aclk),
        .areset      (areset),
        .enable      (enable),
        .cell_bits   (cell_bits),
        .fg_colour   (FG),
        .bg_colour   (BG),
        .grid_colour (GRID),
        .rgb_out     (rgb_out),
        .valid       (valid),
        .ready       (ready),
        .sof         (sof),
        .eol         (eol),
        .frame_done  (frame_done)
    );

    // Beat k of a frame: 4 beats per line, 2 beats per cell column, 2 lines per cell row.
    function automatic logic [191:0] exp_beat(input logic [3:0] bits, input int k);
        int y, bx, col, coff, row, roff;
        logic [23:0]  p;
        logic [191:0] b;
        y = k / 4; bx = k % 4;
        col = bx / 2; coff = (bx % 2) * 8;
        row = y / 2; roff = y % 2;
        b = '0;
        for (int i = 0; i < 8; i++) begin
            if (roff == 0 || (i == 0 && coff == 0)) p = GRID;
            else if (bits[row*2+col]) p = FG;
            else p = BG;
            b[i*24 +: 24] = p;
        end
        return b;
    endfunction

    task automatic do_reset();
        areset = 1'b1; enable = 1'b0; ready = 1'b1; cell_bits = 4'b0110;
        repeat (2) @(posedge aclk);
        #1 areset = 1'b0;
    endtask

    task automatic test_reset();
        areset = 1'b1; enable = 1'b0; ready = 1'b1; cell_bits = 4'b0110;
        repeat (2) @(posedge aclk);
        #1;
        n_cmp++;
        if ({valid, sof, eol, frame_done} !== 4'b0000 || rgb_out !== '0) begin
            n_err++;
            $display("FAIL reset_state: got v/s/e/fd=%b rgb=%h want 0000 rgb=0",
                     {valid, sof, eol, frame_done}, rgb_out);
        end
        areset = 1'b0;
        @(posedge aclk); #1;
        n_cmp++;
        if (valid !== 1'b0) begin
            n_err++;
            $display("FAIL idle_no_enable: got valid=%b want 0", valid);
        end
    endtask

    task automatic test_framing();
        logic [3:0] want;
        do_reset();
        enable = 1'b1;
        for (int k = 0; k <= 16; k++) begin
            @(posedge aclk); #1;
            want = {1'b1, (k % 16) == 0, (k % 4) == 3, k == 16};
            n_cmp++;
            if ({valid, sof, eol, frame_done} !== want) begin
                n_err++;
                $display("FAIL framing_flags beat %0d: got v/s/e/fd=%b want %b",
                         k, {valid, sof, eol, frame_done}, want);
            end
            n_cmp++;
            if (rgb_out !== exp_beat(4'b0110, k % 16)) begin
                n_err++;
                $display("FAIL framing_rgb beat %0d: got %h want %h",
                         k, rgb_out, exp_beat(4'b0110, k % 16));
            end
        end
        @(posedge aclk); #1;
        n_cmp++;
        if (frame_done !== 1'b0) begin
            n_err++;
            $display("FAIL frame_done_width: got %b want 0", frame_done);
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        enable = 1'b1;
        repeat (6) @(posedge aclk);
        #1 ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(posedge aclk); #1;
            n_cmp++;
            if (valid !== 1'b1 || eol !== 1'b0 || rgb_out !== exp_beat(4'b0110, 5)) begin
                n_err++;
                $display("FAIL stall_hold cycle %0d: got v=%b e=%b rgb=%h want v=1 e=0 rgb=%h",
                         c, valid, eol, rgb_out, exp_beat(4'b0110, 5));
            end
        end
        ready = 1'b1;
        @(posedge aclk); #1;
        n_cmp++;
        if (valid !== 1'b1 || rgb_out !== exp_beat(4'b0110, 6)) begin
            n_err++;
            $display("FAIL stall_resume: got v=%b rgb=%h want v=1 rgb=%h",
                     valid, rgb_out, exp_beat(4'b0110, 6));
        end
    endtask

    task automatic test_snapshot();
        logic [3:0] bits;
        do_reset();
        enable = 1'b1;
        for (int k = 0; k <= 20; k++) begin
            @(posedge aclk); #1;
            if (k >= 9) begin
                bits = (k >= 16) ? 4'b1001 : 4'b0110;
                n_cmp++;
                if (rgb_out !== exp_beat(bits, k % 16)) begin
                    n_err++;
                    $display("FAIL snapshot beat %0d: got %h want %h",
                             k, rgb_out, exp_beat(bits, k % 16));
                end
            end
            if (k == 8) cell_bits = 4'b1001;
        end
    endtask

    task automatic test_stop_restart();
        do_reset();
        enable = 1'b1;
        for (int k = 0; k <= 15; k++) begin
            @(posedge aclk); #1;
            if (k == 3) enable = 1'b0;
            if (k >= 4) begin
                n_cmp++;
                if (valid !== 1'b1 || rgb_out !== exp_beat(4'b0110, k)) begin
                    n_err++;
                    $display("FAIL stop_completes beat %0d: got v=%b rgb=%h want v=1 rgb=%h",
                             k, valid, rgb_out, exp_beat(4'b0110, k));
                end
            end
        end
        @(posedge aclk); #1;
        n_cmp++;
        if (valid !== 1'b0 || frame_done !== 1'b1) begin
            n_err++;
            $display("FAIL stop_idle: got v=%b fd=%b want v=0 fd=1", valid, frame_done);
        end
        @(posedge aclk); #1;
        n_cmp++;
        if (valid !== 1'b0 || frame_done !== 1'b0) begin
            n_err++;
            $display("FAIL stop_stays_idle: got v=%b fd=%b want v=0 fd=0", valid, frame_done);
        end
        enable = 1'b1;
        @(posedge aclk); #1;
        n_cmp++;
        if (valid !== 1'b1 || sof !== 1'b1 || rgb_out !== exp_beat(4'b0110, 0)) begin
            n_err++;
            $display("FAIL restart: got v=%b s=%b rgb=%h want v=1 s=1 rgb=%h",
                     valid, sof, rgb_out, exp_beat(4'b0110, 0));
        end
    endtask

    task automatic test_reset_midline();
        do_reset();
        enable = 1'b1;
        repeat (7) @(posedge aclk);
        #3 areset = 1'b1;
        #1;
        n_cmp++;
        if ({valid, sof, eol} !== 3'b000 || rgb_out !== '0) begin
            n_err++;
            $display("FAIL async_reset: got v/s/e=%b rgb=%h want 000 rgb=0",
                     {valid, sof, eol}, rgb_out);
        end
        @(posedge aclk);
        #1 areset = 1'b0;
        @(posedge aclk); #1;
        n_cmp++;
        if (valid !== 1'b1 || sof !== 1'b1 || rgb_out !== exp_beat(4'b0110, 0)) begin
            n_err++;
            $display("FAIL reset_resync: got v=%b s=%b rgb=%h want v=1 s=1 rgb=%h",
                     valid, sof, rgb_out, exp_beat(4'b0110, 0));
        end
    endtask

    initial begin
        test_reset();
        test_framing();
        test_backpressure();
        test_snapshot();
        test_stop_restart();
        test_reset_midline();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
